// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Purpose  : Shared definitions for the data-bus memory responder:
//             FSM state encoding, store-size codes and the sub-word
//             store lane-merge helper.
//  Revision : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Merge right-aligned store data into an existing word.
    // Byte lane is lane[1:0], half lane is lane[1]; 2'b11 behaves as a word.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] w;
        w = old_word;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    w[7:0]   = wdata[7:0];
                    2'd1:    w[15:8]  = wdata[7:0];
                    2'd2:    w[23:16] = wdata[7:0];
                    default: w[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) w[31:16] = wdata[15:0];
                else         w[15:0]  = wdata[15:0];
            end
            default: w = wdata;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_array
//  Purpose  : DEPTH x 32 storage, one synchronous read port and one write
//             port sharing a single address. Read returns the pre-write
//             contents when read and write hit the same word on one edge.
//  Ports    : clock  - rising-edge clock
//             we     - write enable
//             addr   - word index
//             wdata  - write data
//             rdata  - registered read data (valid the cycle after addr)
//  Revision : 1.0  initial release
// ============================================================================
module mem_word_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // Contents are deliberately not reset.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory-side slave for the CPU data bus. Accepts one request at
//             a time, inserts WAIT_STATES cycles, performs loads, word stores
//             and read-modify-write sub-word stores, and returns exactly one
//             resp_valid pulse per accepted request.
//  Config   : MEM_ALIGN_CHECK_EN - when defined, misaligned half/word
//             accesses are rejected through the error path.
//  Ports    : clock, reset      - clock, synchronous active-high reset
//             req_valid/ready   - request handshake (ready only in IDLE)
//             req_addr          - byte address, word index = addr[31:2]
//             req_wr, req_size  - store flag, store width (00/01/10, 11=word)
//             req_wdata         - right-aligned store data
//             resp_valid        - one-cycle response pulse
//             resp_rdata        - load word / written word / 0 on error
//             resp_err          - out-of-range or misaligned request
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_DEPTH     = 32'(DEPTH);
    // Counter is preloaded so that WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]           lane_q, lane_d;
    logic [1:0]           size_q, size_d;
    logic                 wr_q, wr_d;
    logic                 err_q, err_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          result_q, result_d;

    logic                 range_err;
    logic                 align_err;
    logic                 arr_we;
    logic [31:0]          arr_rdata;
    logic [31:0]          merged;

    assign range_err = ({2'b00, req_addr[31:2]} >= c_DEPTH);

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        align_err = 1'b0;
        if (req_wr && (req_size == SIZE_BYTE)) begin
            align_err = 1'b0;
        end else if (req_wr && (req_size == SIZE_HALF)) begin
            align_err = req_addr[0];
        end else begin
            // Loads and word stores (size 10 or 11) must be word aligned.
            align_err = (req_addr[1:0] != 2'b00);
        end
    end
`else
    assign align_err = 1'b0;
`endif

    assign merged = merge_store(arr_rdata, wdata_q, size_q, lane_q);

    // Reset overrides a write that would otherwise land on this edge.
    mem_word_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_IDX_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we && !reset),
        .addr  (idx_q),
        .wdata (merged),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            lane_q   <= 2'b00;
            size_q   <= 2'b00;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        size_d     = size_q;
        wr_d       = wr_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        arr_we     = 1'b0;
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = (state_q == S_RESP) && err_q;
        resp_rdata = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[c_IDX_W+1:2];
                    lane_d  = req_addr[1:0];
                    size_d  = req_size;
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    err_d   = range_err || align_err;
                    if (range_err || align_err) begin
                        state_d = S_RESP;
                    end else if (WAIT_STATES > 0) begin
                        cnt_d   = c_WAIT_INIT;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_FETCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_FETCH: begin
                state_d = wr_q ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                // The fetched word is on arr_rdata now; keep the merged
                // result because the array read port shows the old value
                // during the RESP cycle.
                arr_we   = 1'b1;
                result_d = merged;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (!err_q) resp_rdata = wr_q ? result_q : arr_rdata;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench. Two responders share a clock: instance 0
//             (DEPTH=256, no wait states) and instance 1 (DEPTH=64, three
//             wait states). A byte-level reference memory predicts every
//             response word, error flag and response cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;
    import mem_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset;
    logic [1:0]       req_valid, req_ready, req_wr, resp_valid, resp_err;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0][1:0]  req_size;

    mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clock(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wr(req_wr[0]), .req_size(req_size[0]),
        .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    mem_responder #(.DEPTH(64), .WAIT_STATES(3)) u_dut1 (
        .clock(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wr(req_wr[1]), .req_size(req_size[1]),
        .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [2][256];

    function automatic int dep(input int k);
        return (k == 0) ? 256 : 64;
    endfunction

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic model_err(input int k, input logic [31:0] addr,
                                       input logic wr, input logic [1:0] size);
        logic e;
        e = ((addr >> 2) >= 32'(dep(k)));
`ifdef MEM_ALIGN_CHECK_EN
        if (!wr || size >= 2'd2) e = e || ((addr % 4) != 0);
        else if (size == 2'd1)   e = e || ((addr % 2) != 0);
`endif
        return e;
    endfunction

    // Byte-oriented view of a store: replace the addressed bytes.
    function automatic logic [31:0] model_store(input logic [31:0] old_w, input logic [31:0] addr,
                                                input logic [1:0] size, input logic [31:0] wdata);
        logic [7:0] b [4];
        int base;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) b[i] = old_w[8*i +: 8];
        if (size == 2'd0) begin
            b[addr % 4] = wdata[7:0];
        end else if (size == 2'd1) begin
            base = int'(((addr / 2) % 2) * 2);
            b[base]     = wdata[7:0];
            b[base + 1] = wdata[15:8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = wdata[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with instance k idle. Returns at the falling
    // edge of the cycle after RESP, so the next call is back-to-back.
    task automatic txn(input int k, input logic [31:0] addr, input logic wr,
                       input logic [1:0] size, input logic [31:0] wdata);
        logic        e;
        logic [31:0] exp_d;
        logic [31:0] new_w;
        int          lat;
        int          idx;
        bit          seen;
        e     = model_err(k, addr, wr, size);
        idx   = int'(addr >> 2);
        new_w = 32'd0;
        if (e) begin
            exp_d = 32'd0;
            lat   = 1;
        end else if (wr) begin
            new_w = model_store(mdl[k][idx], addr, size, wdata);
            exp_d = new_w;
            lat   = ws(k) + 3;
        end else begin
            exp_d = mdl[k][idx];
            lat   = ws(k) + 2;
        end
        chk("ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        req_wr[k]    = wr;
        req_size[k]  = size;
        req_wdata[k] = wdata;
        @(posedge clk);
        #1;
        // Garbage on the bus while busy must be ignored.
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        req_wr[k]    = 1'($urandom);
        req_size[k]  = 2'($urandom);
        req_wdata[k] = $urandom;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            chk("ready_busy", 32'(req_ready[k]), 32'd0);
            if (resp_valid[k]) begin
                seen = 1'b1;
                chk("resp_cycle", 32'(c), 32'(lat));
                chk("resp_rdata", resp_rdata[k], exp_d);
                chk("resp_err", 32'(resp_err[k]), 32'(e));
            end
        end
        chk("resp_seen", 32'(seen), 32'd1);
        if (!e && wr) mdl[k][idx] = new_w;
        @(negedge clk);
        chk("valid_single", 32'(resp_valid[k]), 32'd0);
    endtask

    // Word store aborted by reset held through its WRITE cycle.
    task automatic reset_in_write(input int k, input logic [31:0] addr, input logic [31:0] wdata);
        chk("ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        req_wr[k]    = 1'b1;
        req_size[k]  = SIZE_WORD;
        req_wdata[k] = wdata;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        for (int c = 1; c <= ws(k) + 2; c++) begin
            @(negedge clk);
            chk("rst_no_early_resp", 32'(resp_valid[k]), 32'd0);
        end
        reset[k] = 1'b1;
        @(negedge clk);
        chk("rst_no_resp", 32'(resp_valid[k]), 32'd0);
        reset[k] = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 32'(req_ready[k]), 32'd1);
        chk("rst_no_resp_after", 32'(resp_valid[k]), 32'd0);
    endtask

    initial begin
        int k;
        int r;
        logic [31:0] a;
        reset     = 2'b11;
        req_valid = '0;
        req_addr  = '0;
        req_wr    = '0;
        req_size  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", 32'(req_ready[i]), 32'd1);
            chk("reset_valid", 32'(resp_valid[i]), 32'd0);
            chk("reset_rdata", resp_rdata[i], 32'd0);
            chk("reset_err", 32'(resp_err[i]), 32'd0);
        end
        reset = 2'b00;
        @(negedge clk);

        // Give every word a known value.
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < dep(i); w++)
                txn(i, 32'(w * 4), 1'b1, SIZE_WORD, $urandom);

        // Directed cases.
        txn(0, 32'h10, 1'b1, SIZE_WORD, 32'hDEADBEEF);
        txn(0, 32'h10, 1'b0, SIZE_WORD, 32'h0);
        txn(0, 32'h10, 1'b1, SIZE_WORD, 32'h11223344);
        txn(0, 32'h12, 1'b1, SIZE_BYTE, 32'h000000AA);
        txn(0, 32'h10, 1'b0, SIZE_WORD, 32'h0);
        txn(1, 32'h20, 1'b1, SIZE_WORD, 32'h0);
        txn(1, 32'h22, 1'b1, SIZE_HALF, 32'h0000BEEF);
        txn(1, 32'h20, 1'b0, SIZE_WORD, 32'h0);
        txn(0, 32'h400, 1'b0, SIZE_WORD, 32'h0);
        txn(0, 32'h400, 1'b1, SIZE_WORD, 32'hFFFFFFFF);
        txn(0, 32'h0, 1'b0, SIZE_WORD, 32'h0);
        txn(1, 32'h100, 1'b1, SIZE_BYTE, 32'h55);
        txn(1, 32'h0, 1'b0, SIZE_WORD, 32'h0);
        txn(0, 32'h11, 1'b0, SIZE_WORD, 32'h0);
        txn(0, 32'h13, 1'b1, SIZE_HALF, 32'h00007777);
        txn(0, 32'h17, 1'b1, SIZE_BYTE, 32'h00000099);
        txn(0, 32'h1A, 1'b1, 2'b11, 32'hCAFEF00D);
        txn(0, 32'h10, 1'b0, SIZE_WORD, 32'h0);
        txn(0, 32'h14, 1'b0, SIZE_WORD, 32'h0);
        txn(0, 32'h18, 1'b0, SIZE_WORD, 32'h0);

        // Randomized traffic over both instances.
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(dep(k) * 4) + 32'($urandom_range(0, 15));
            else             a = (32'($urandom_range(0, dep(k) - 1)) << 2) | 32'($urandom_range(0, 3));
            txn(k, a, 1'($urandom), 2'($urandom), $urandom);
        end

        // Reset during the WRITE cycle: the target word must be untouched.
        reset_in_write(0, 32'h40, 32'h0BADF00D);
        txn(0, 32'h40, 1'b0, SIZE_WORD, 32'h0);
        reset_in_write(1, 32'h3C, 32'h0BADF00D);
        txn(1, 32'h3C, 1'b0, SIZE_WORD, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
